date_sequencer: RTL and testbench
=================================

Name: date_sequencer

Overview:
- Calendar-walk controller for the month/day validity datapath (12 months, per-month day-valid bitmap, Feb = 28 days by default).
- Accepts a start date and a count, checks the start date against the day-per-month table, then emits the requested number of consecutive valid dates, one per handshake.
- Sits between a command source and any consumer that iterates over calendar dates. Rolls over Dec 31 -> Jan 1 and flags the rollover.

Parameters:
- COUNT_W, 9, width of the date-count field (max request 2^COUNT_W-1 dates).
- LEAP_EN, 0, 1 = February has 29 days; 0 = February has 28 days.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  command valid.
- in_ready  output  1  command accepted when in_valid & in_ready.
- in_month  input  4  start month, 1..12.
- in_day  input  5  start day, 1..days_in_month.
- in_count  input  COUNT_W  number of dates to emit, >= 1.
- out_valid  output  1  date beat valid.
- out_ready  input  1  consumer ready.
- out_month  output  4  emitted month.
- out_day  output  5  emitted day.
- out_last  output  1  final beat of the command.
- out_wrap  output  1  this beat is Jan 1 reached by rollover from Dec 31.
- err  output  1  one-cycle pulse: command rejected.

Behaviour:
- Days-in-month table: Jan, Mar, May, Jul, Aug, Oct, Dec = 31; Apr, Jun, Sep, Nov = 30; Feb = 28 (29 if LEAP_EN=1). Implemented as a combinational lookup on month.
- Reset (async, immediate):
  - state = IDLE; in_ready = 1.
  - out_valid, out_last, out_wrap and err = 0.
  - out_month, out_day and the remaining-count register = 0.
- State IDLE:
  - in_ready = 1, out_valid = 0.
  - On accept, the command is rejected if in_month is 0 or >12, in_day is 0 or > days_in_month(in_month), or in_count is 0.
  - Rejected command: err = 1 for exactly the next cycle, state stays IDLE, no out_valid.
  - Accepted command: cur_month/cur_day <= start, remaining <= in_count, wrap flag <= 0, state <= RUN.
- State RUN:
  - in_ready = 0 (incoming in_valid is ignored, never latched). out_valid = 1.
  - out_month/out_day = current date. out_last = (remaining == 1). out_wrap = wrap flag.
  - Latency: first out_valid in the cycle after the accept edge.
  - While out_valid & !out_ready, all out_* hold stable.
  - On out_valid & out_ready with remaining == 1: state <= IDLE, out_valid falls next cycle.
  - On out_valid & out_ready with remaining > 1: remaining decrements and the date advances:
    - day < dim(month): day + 1.
    - day == dim(month) and month < 12: month + 1, day = 1.
    - Dec 31: month = 1, day = 1, wrap flag <= 1.
    - Wrap flag clears on any other advance.
  - Throughput: one date per cycle under continuous out_ready.
- Back-to-back commands: in_ready returns only in IDLE. There is a minimum of one idle cycle between the last beat of one command and acceptance of the next.
- After completion, out_month/out_day hold the last emitted date. out_last and out_wrap are 0 whenever out_valid = 0.
- Multiple rollovers within one command are allowed (count > 365); each Jan 1 produced by rollover asserts out_wrap.
- Reset asserted mid-RUN: the command is abandoned immediately and all outputs go to their reset values. No partial-beat completion.
- Remaining count is COUNT_W bits wide and never underflows, because decrement occurs only when remaining > 1.

Test Plan:
- Month boundary: start 1/30, count 3, out_ready = 1 -> beats 1/30, 1/31, 2/1 on consecutive cycles; out_last only on 2/1; in_ready high again the cycle after.
- February, LEAP_EN=0: start 2/28, count 2 -> 2/28, 3/1. With LEAP_EN=1 the same command -> 2/28, 2/29.
- Rollover: start 12/31, count 3 -> 12/31 (wrap 0), 1/1 (wrap 1), 1/2 (wrap 0, last 1).
- Reject: inputs 4/31, 13/1, 2/29 (LEAP_EN=0), 5/0 and count 0 -> each gives err high exactly one cycle, no out_valid, in_ready stays 1.
- Backpressure and reset:
  - Start 6/29, count 3; out_ready low for 3 cycles on beat 2 -> 6/30 held stable, then 7/1.
  - Separately, assert rst during beat 2 -> out_valid = 0 immediately and in_ready = 1.
- Full year: start 3/1, count 366 -> last beat is 3/1 of the next cycle-year; exactly one out_wrap beat (1/1); 366 handshakes total.

Source files
------------

// File: rtl/date_sequencer.sv
// Calendar-walk controller: validates a start date against the days-in-month
// table and then emits a run of consecutive dates, one per output handshake.
// Rolls Dec 31 over to Jan 1 and marks that beat with out_wrap.
module date_sequencer #(
  parameter int COUNT_W = 9,
  parameter bit LEAP_EN = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_month,
  input  logic [4:0]         in_day,
  input  logic [COUNT_W-1:0] in_count,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_month,
  output logic [4:0]         out_day,
  output logic               out_last,
  output logic               out_wrap,
  output logic               err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [COUNT_W-1:0] CNT_ZERO = {COUNT_W{1'b0}};
  localparam logic [COUNT_W-1:0] CNT_ONE  = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] CNT_TWO  = COUNT_W'(2);

  state_t             state_r;
  logic [COUNT_W-1:0] rem_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [3:0]         out_month_r;
  logic [4:0]         out_day_r;
  logic               out_last_r;
  logic               out_wrap_r;
  logic               err_r;

  logic               cmd_ok_s;
  logic [3:0]         nxt_month_s;
  logic [4:0]         nxt_day_s;
  logic               nxt_wrap_s;

  // Days in a month; out-of-range months fall to 31 but are screened separately.
  function automatic logic [4:0] dim_f(input logic [3:0] m);
    logic [4:0] d;
    case (m)
      4'd2:                     d = LEAP_EN ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:  d = 5'd30;
      default:                  d = 5'd31;
    endcase
    return d;
  endfunction

  // Screen an incoming command: legal month, legal day for that month, nonzero count.
  always_comb begin
    cmd_ok_s = 1'b0;
    if ((in_month >= 4'd1) && (in_month <= 4'd12) &&
        (in_day != 5'd0) && (in_day <= dim_f(in_month)) &&
        (in_count != CNT_ZERO)) begin
      cmd_ok_s = 1'b1;
    end else begin
      cmd_ok_s = 1'b0;
    end
  end

  // Successor of the date currently on the output, with year-rollover detect.
  always_comb begin
    nxt_month_s = out_month_r;
    nxt_day_s   = out_day_r + 5'd1;
    nxt_wrap_s  = 1'b0;
    if (out_day_r < dim_f(out_month_r)) begin
      nxt_month_s = out_month_r;
      nxt_day_s   = out_day_r + 5'd1;
    end else if (out_month_r < 4'd12) begin
      nxt_month_s = out_month_r + 4'd1;
      nxt_day_s   = 5'd1;
    end else begin
      nxt_month_s = 4'd1;
      nxt_day_s   = 5'd1;
      nxt_wrap_s  = 1'b1;
    end
  end

  // Control FSM with all outputs registered; the output date doubles as the walk cursor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      rem_r       <= CNT_ZERO;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_month_r <= 4'd0;
      out_day_r   <= 5'd0;
      out_last_r  <= 1'b0;
      out_wrap_r  <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          err_r <= 1'b0;
          if (in_valid) begin
            if (cmd_ok_s) begin
              state_r     <= RUN;
              rem_r       <= in_count;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
              out_month_r <= in_month;
              out_day_r   <= in_day;
              out_last_r  <= (in_count == CNT_ONE);
              out_wrap_r  <= 1'b0;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        RUN: begin
          err_r <= 1'b0;
          if (out_ready) begin
            if (rem_r == CNT_ONE) begin
              // Final beat taken: keep the last date visible, drop the beat flags.
              state_r     <= IDLE;
              in_ready_r  <= 1'b1;
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              out_wrap_r  <= 1'b0;
            end else begin
              rem_r       <= rem_r - CNT_ONE;
              out_month_r <= nxt_month_s;
              out_day_r   <= nxt_day_s;
              out_last_r  <= (rem_r == CNT_TWO);
              out_wrap_r  <= nxt_wrap_s;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
          out_wrap_r  <= 1'b0;
          err_r       <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_month = out_month_r;
  assign out_day   = out_day_r;
  assign out_last  = out_last_r;
  assign out_wrap  = out_wrap_r;
  assign err       = err_r;

endmodule

// File: tb/tb_date_sequencer.sv
// Directed, table-driven bench for date_sequencer, plus hand-written
// sequences for leap February, backpressure, mid-run reset and a full year.
module tb_date_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_valid_l = 1'b0;
  logic [3:0] in_month = 4'd0;
  logic [4:0] in_day = 5'd0;
  logic [8:0] in_count = 9'd0;
  logic       out_ready = 1'b1;

  logic       in_ready, out_valid, out_last, out_wrap, err;
  logic [3:0] out_month;
  logic [4:0] out_day;
  logic       l_in_ready, l_out_valid, l_out_last, l_out_wrap, l_err;
  logic [3:0] l_out_month;
  logic [4:0] l_out_day;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  date_sequencer #(.COUNT_W(9), .LEAP_EN(1'b0)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_month(in_month), .in_day(in_day), .in_count(in_count),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_month(out_month), .out_day(out_day),
    .out_last(out_last), .out_wrap(out_wrap), .err(err)
  );

  date_sequencer #(.COUNT_W(9), .LEAP_EN(1'b1)) dut_leap (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_l), .in_ready(l_in_ready),
    .in_month(in_month), .in_day(in_day), .in_count(in_count),
    .out_valid(l_out_valid), .out_ready(out_ready),
    .out_month(l_out_month), .out_day(l_out_day),
    .out_last(l_out_last), .out_wrap(l_out_wrap), .err(l_err)
  );

  typedef struct packed {
    logic [3:0]      m;
    logic [4:0]      d;
    logic [8:0]      cnt;
    logic            rej;
    logic [1:0]      n;
    logic [0:2][3:0] em;
    logic [0:2][4:0] ed;
    logic [0:2]      ew;
  } vec_t;

  vec_t vec [9];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Apply one table entry to the LEAP_EN=0 instance and check every beat.
  task automatic run_vec(input int i);
    vec_t v;
    v = vec[i];
    @(negedge clk);
    chk($sformatf("v%0d in_ready before", i), int'(in_ready), 1);
    in_valid = 1'b1; in_month = v.m; in_day = v.d; in_count = v.cnt;
    @(negedge clk);
    in_valid = 1'b0;
    if (v.rej) begin
      chk($sformatf("v%0d err pulse", i), int'(err), 1);
      chk($sformatf("v%0d no out_valid", i), int'(out_valid), 0);
      chk($sformatf("v%0d in_ready held", i), int'(in_ready), 1);
      @(negedge clk);
      chk($sformatf("v%0d err cleared", i), int'(err), 0);
      chk($sformatf("v%0d still idle", i), int'(out_valid), 0);
    end else begin
      for (int k = 0; k < int'(v.n); k++) begin
        chk($sformatf("v%0d b%0d valid", i, k), int'(out_valid), 1);
        chk($sformatf("v%0d b%0d month", i, k), int'(out_month), int'(v.em[k]));
        chk($sformatf("v%0d b%0d day", i, k), int'(out_day), int'(v.ed[k]));
        chk($sformatf("v%0d b%0d last", i, k), int'(out_last), (k == int'(v.n) - 1) ? 1 : 0);
        chk($sformatf("v%0d b%0d wrap", i, k), int'(out_wrap), int'(v.ew[k]));
        chk($sformatf("v%0d b%0d in_ready", i, k), int'(in_ready), 0);
        @(negedge clk);
      end
      chk($sformatf("v%0d done valid", i), int'(out_valid), 0);
      chk($sformatf("v%0d done in_ready", i), int'(in_ready), 1);
      chk($sformatf("v%0d done last", i), int'(out_last), 0);
      chk($sformatf("v%0d hold month", i), int'(out_month), int'(v.em[int'(v.n) - 1]));
      chk($sformatf("v%0d hold day", i), int'(out_day), int'(v.ed[int'(v.n) - 1]));
    end
  endtask

  initial begin
    int beats, wraps, wrap_m, wrap_d, last_m, last_d;
    bit done;

    vec[0] = '{4'd1,  5'd30, 9'd3, 1'b0, 2'd3, {4'd1, 4'd1, 4'd2},  {5'd30, 5'd31, 5'd1}, 3'b000};
    vec[1] = '{4'd2,  5'd28, 9'd2, 1'b0, 2'd2, {4'd2, 4'd3, 4'd0},  {5'd28, 5'd1, 5'd0},  3'b000};
    vec[2] = '{4'd12, 5'd31, 9'd3, 1'b0, 2'd3, {4'd12, 4'd1, 4'd1}, {5'd31, 5'd1, 5'd2},  3'b010};
    vec[3] = '{4'd4,  5'd31, 9'd1, 1'b1, 2'd0, {4'd0, 4'd0, 4'd0},  {5'd0, 5'd0, 5'd0},   3'b000};
    vec[4] = '{4'd13, 5'd1,  9'd1, 1'b1, 2'd0, {4'd0, 4'd0, 4'd0},  {5'd0, 5'd0, 5'd0},   3'b000};
    vec[5] = '{4'd2,  5'd29, 9'd1, 1'b1, 2'd0, {4'd0, 4'd0, 4'd0},  {5'd0, 5'd0, 5'd0},   3'b000};
    vec[6] = '{4'd5,  5'd0,  9'd1, 1'b1, 2'd0, {4'd0, 4'd0, 4'd0},  {5'd0, 5'd0, 5'd0},   3'b000};
    vec[7] = '{4'd5,  5'd1,  9'd0, 1'b1, 2'd0, {4'd0, 4'd0, 4'd0},  {5'd0, 5'd0, 5'd0},   3'b000};
    vec[8] = '{4'd11, 5'd30, 9'd2, 1'b0, 2'd2, {4'd11, 4'd12, 4'd0},{5'd30, 5'd1, 5'd0},  3'b000};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst in_ready", int'(in_ready), 1);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst err", int'(err), 0);
    chk("rst month", int'(out_month), 0);
    chk("rst day", int'(out_day), 0);
    chk("rst last", int'(out_last), 0);
    chk("rst wrap", int'(out_wrap), 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(i);

    // Leap February on the LEAP_EN=1 instance: 2/28 count 2 -> 2/28, 2/29.
    @(negedge clk);
    in_valid_l = 1'b1; in_month = 4'd2; in_day = 5'd28; in_count = 9'd2;
    @(negedge clk);
    in_valid_l = 1'b0;
    chk("leap b0 day", int'(l_out_day), 28);
    chk("leap b0 last", int'(l_out_last), 0);
    @(negedge clk);
    chk("leap b1 month", int'(l_out_month), 2);
    chk("leap b1 day", int'(l_out_day), 29);
    chk("leap b1 last", int'(l_out_last), 1);
    @(negedge clk);
    chk("leap done valid", int'(l_out_valid), 0);

    // Backpressure: 6/29 count 3, stall three cycles on beat 2; a stray command is ignored.
    @(negedge clk);
    in_valid = 1'b1; in_month = 4'd6; in_day = 5'd29; in_count = 9'd3;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp b0 day", int'(out_day), 29);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_month = 4'd1; in_day = 5'd1; in_count = 9'd5;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp stall%0d valid", k), int'(out_valid), 1);
      chk($sformatf("bp stall%0d month", k), int'(out_month), 6);
      chk($sformatf("bp stall%0d day", k), int'(out_day), 30);
      chk($sformatf("bp stall%0d last", k), int'(out_last), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp b2 month", int'(out_month), 7);
    chk("bp b2 day", int'(out_day), 1);
    chk("bp b2 last", int'(out_last), 1);
    @(negedge clk);
    chk("bp done valid", int'(out_valid), 0);
    chk("bp done in_ready", int'(in_ready), 1);

    // Reset during beat 2 abandons the command at once.
    @(negedge clk);
    in_valid = 1'b1; in_month = 4'd6; in_day = 5'd29; in_count = 9'd3;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("mr beat2 day", int'(out_day), 30);
    rst = 1'b1;
    #1;
    chk("mr out_valid", int'(out_valid), 0);
    chk("mr in_ready", int'(in_ready), 1);
    chk("mr month", int'(out_month), 0);
    chk("mr day", int'(out_day), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mr stays idle", int'(out_valid), 0);

    // Full year: 3/1 count 366 ends on 3/1 with a single wrap beat at 1/1.
    in_valid = 1'b1; in_month = 4'd3; in_day = 5'd1; in_count = 9'd366;
    @(negedge clk);
    in_valid = 1'b0;
    beats = 0; wraps = 0; wrap_m = 0; wrap_d = 0; last_m = 0; last_d = 0; done = 1'b0;
    for (int c = 0; c < 500 && !done; c++) begin
      if (out_valid) begin
        beats++;
        if (out_wrap) begin
          wraps++;
          wrap_m = int'(out_month);
          wrap_d = int'(out_day);
        end
        if (out_last) begin
          done = 1'b1;
          last_m = int'(out_month);
          last_d = int'(out_day);
        end
      end
      @(negedge clk);
    end
    chk("year done", int'(done), 1);
    chk("year beats", beats, 366);
    chk("year wraps", wraps, 1);
    chk("year wrap month", wrap_m, 1);
    chk("year wrap day", wrap_d, 1);
    chk("year last month", last_m, 3);
    chk("year last day", last_d, 1);
    chk("year idle after", int'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
